rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: INIT_EN, 1, when 1 sequence a clear of x1..x31 after reset.
REQ-002 SHALL have parameter: INIT_VALUE, 32'h0, data written to each register during the clear sequence.
REQ-003 SHALL have ports (name direction width meaning):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- alu_valid_i  in  1  ALU writeback request
- alu_addr_i  in  5  ALU destination register
- alu_data_i  in  32  ALU writeback data
- alu_ready_o  out  1  ALU request accepted this cycle
- lsu_valid_i  in  1  LSU load writeback request
- lsu_addr_i  in  5  LSU destination register
- lsu_data_i  in  32  LSU writeback data
- lsu_ready_o  out  1  LSU request accepted this cycle
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  5  register-file write address (registered)
- rf_wdata_o  out  32  register-file write data (registered)
- init_done_o  out  1  clear sequence complete; arbitration active

Function
REQ-004 SHALL implement states INIT and RUN; reset enters INIT with counter = 1 when INIT_EN = 1, else RUN.
REQ-005 In INIT, SHALL present one write per cycle: rf_we_o = 1, rf_waddr_o = counter, rf_wdata_o = INIT_VALUE, for counter 1..31 in order, starting the first cycle after rst_i is sampled low.
REQ-006 SHALL never write address 0 during INIT; the counter is 5 bits and does not wrap past 31.
REQ-007 SHALL transition INIT -> RUN after the address-31 write; init_done_o = 1 from the cycle after the address-31 write is presented, and in every RUN cycle.
REQ-008 With INIT_EN = 0, init_done_o SHALL be 1 from the first cycle after reset is released.
REQ-009 In INIT, alu_ready_o and lsu_ready_o SHALL be 0.
REQ-010 In RUN, ready outputs SHALL be combinational on the valids and the priority pointer: ready = own valid AND (other valid low OR pointer selects self).
REQ-011 At most one ready SHALL be high in any cycle; ready SHALL never be high while its valid is low.
REQ-012 Priority pointer SHALL reset to ALU and SHALL toggle to the loser only after a contested cycle (both valids high); uncontested grants leave it unchanged.
REQ-013 Requesters SHALL hold valid, addr and data stable until ready; the arbiter captures on the valid & ready edge.
REQ-014 An accepted request in cycle N SHALL appear on rf_we_o/rf_waddr_o/rf_wdata_o in cycle N+1; latency is exactly 1 cycle.
REQ-015 An accepted request with addr = 0 SHALL complete its handshake but SHALL produce rf_we_o = 0 in cycle N+1.
REQ-016 In a cycle with no accepted request, rf_we_o SHALL be 0 in the following cycle; rf_waddr_o and rf_wdata_o hold their last values.
REQ-017 Simultaneous requests to the same address SHALL be written in grant order; the later-granted value is the final register content.
REQ-018 Sustained throughput SHALL be one write per cycle; neither requester waits more than one cycle while the other is continuously valid.

Reset
REQ-019 On rst_i = 1 at a clock edge, next cycle: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, init_done_o = 0 (INIT_EN = 1), both readies 0, pointer = ALU.
REQ-020 Reset asserted mid-INIT SHALL restart the clear sequence at address 1; reset asserted in RUN SHALL drop any write pending for the next cycle.
REQ-021 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-022 Reset release, INIT_EN = 1 -> 31 consecutive writes, addr 1..31, data INIT_VALUE; init_done_o rises the next cycle; readies 0 throughout.
REQ-023 RUN, ALU only, addr 5, data 32'hDEADBEEF -> alu_ready_o = 1 the same cycle; next cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 32'hDEADBEEF.
REQ-024 RUN, both valid for 4 cycles (ALU addr 1, LSU addr 2) -> grants ALU, LSU, ALU, LSU; writes to 1, 2, 1, 2 each one cycle later.
REQ-025 RUN, LSU addr 0, data 32'h12345678 -> lsu_ready_o = 1; next cycle rf_we_o = 0.
REQ-026 Assert rst_i at INIT address 10 -> next cycle rf_we_o = 0; after release the sequence restarts at address 1 and completes at address 31.
REQ-027 Both valid to address 7 (ALU 32'h1, LSU 32'h2), pointer = ALU -> writes 32'h1 then 32'h2 to address 7; final register value 32'h2.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Merges ALU and LSU writeback requests onto a single registered write port,
// using round-robin priority that only moves after a contested cycle. After
// reset it can optionally sweep x1..x31 with INIT_VALUE before arbitration
// is enabled.
module rf_wb_arbiter #(
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        init_done_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Pointer encoding: 0 favours the ALU, 1 favours the LSU.
  localparam logic PTR_ALU = 1'b0;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        ptr_r, ptr_s;
  logic        init_done_r;
  logic        rf_we_r, rf_we_s;
  logic [4:0]  rf_waddr_r, rf_waddr_s;
  logic [31:0] rf_wdata_r, rf_wdata_s;
  logic        alu_ready_s, lsu_ready_s, contested_s;

  // Grant logic: combinational on the valids and the pointer, and only once
  // the clear sweep is over (init_done_r), so no grant leaks into the
  // cycle that presents the final clear write.
  always_comb begin
    alu_ready_s = 1'b0;
    lsu_ready_s = 1'b0;
    contested_s = 1'b0;
    if (init_done_r) begin
      contested_s = alu_valid_i & lsu_valid_i;
      alu_ready_s = alu_valid_i & (~lsu_valid_i | (ptr_r == PTR_ALU));
      lsu_ready_s = lsu_valid_i & (~alu_valid_i | (ptr_r != PTR_ALU));
    end else begin
      alu_ready_s = 1'b0;
      lsu_ready_s = 1'b0;
      contested_s = 1'b0;
    end
  end

  // Next-state, clear counter, pointer and next write-port contents.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ptr_s      = ptr_r;
    rf_we_s    = 1'b0;
    rf_waddr_s = rf_waddr_r;
    rf_wdata_s = rf_wdata_r;
    case (state_r)
      ST_INIT: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = cnt_r;
        rf_wdata_s = INIT_VALUE;
        if (cnt_r == 5'd31) begin
          // Counter parks at 31; it never wraps back to x0.
          state_s = ST_RUN;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      ST_RUN: begin
        if (alu_ready_s) begin
          // Writes to x0 complete the handshake but never reach the file.
          rf_we_s    = (alu_addr_i != 5'd0);
          rf_waddr_s = alu_addr_i;
          rf_wdata_s = alu_data_i;
        end else if (lsu_ready_s) begin
          rf_we_s    = (lsu_addr_i != 5'd0);
          rf_waddr_s = lsu_addr_i;
          rf_wdata_s = lsu_data_i;
        end else begin
          rf_we_s = 1'b0;
        end
        // The winner of a contested cycle is always ptr_r, so toggling hands
        // priority to the loser; uncontested grants leave it alone.
        if (contested_s) begin
          ptr_s = ~ptr_r;
        end else begin
          ptr_s = ptr_r;
        end
      end
      default: begin
        state_s = ST_RUN;
        rf_we_s = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over everything,
  // including a write that would otherwise be presented next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= (INIT_EN == 1'b1) ? ST_INIT : ST_RUN;
      cnt_r       <= 5'd1;
      ptr_r       <= PTR_ALU;
      init_done_r <= 1'b0;
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= 5'd0;
      rf_wdata_r  <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ptr_r       <= ptr_s;
      init_done_r <= (state_r == ST_RUN);
      rf_we_r     <= rf_we_s;
      rf_waddr_r  <= rf_waddr_s;
      rf_wdata_r  <= rf_wdata_s;
    end
  end

  assign alu_ready_o = alu_ready_s;
  assign lsu_ready_o = lsu_ready_s;
  assign rf_we_o     = rf_we_r;
  assign rf_waddr_o  = rf_waddr_r;
  assign rf_wdata_o  = rf_wdata_r;
  assign init_done_o = init_done_r;

endmodule
